intrude_arbiter: RTL and testbench
==================================

INTRUDE_ARBITER -- requirements
Module: intrude_arbiter

Interface
REQ-001 Parameter CYC_LEN, default 3: CLK cycles RD or WR is held per intrusion transfer (legal 1..15).
REQ-002 Parameter MAX_BURST, default 4: consecutive transfers allowed before the bus is released (legal 1..15).
REQ-003 Parameter GAP, default 2: CLK cycles TRUDY is held low after a forced release (legal 1..15).
REQ-004 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 REQ  in  3  per-requester intrusion request, level; bit0 DSP, bit1 blitter, bit2 external DMA.
REQ-007 REQWR  in  3  per-requester direction, sampled with REQ; 1 = write, 0 = read.
REQ-008 BUSACK  in  1  intrusion sequencer owns the bus; 1 = transfer may run.
REQ-009 TRUDY  out  1  intrusion request to the intrusion sequencer.
REQ-010 RD  out  1  read strobe to the intrusion sequencer.
REQ-011 WR  out  1  write strobe to the intrusion sequencer.
REQ-012 GNT  out  3  one-hot grant to the current winner; drives the external address/data mux.
REQ-013 DONE  out  3  one-cycle pulse to the winner on transfer completion.

Function
REQ-014 States: IDLE, ACQ, XFER, NEXT, HOLD; encoding is free.
REQ-015 Arbitration: REQ[0] has fixed top priority; REQ[1] and REQ[2] share round-robin; the pointer moves to the other one only after a completed transfer by one of them.
REQ-016 IDLE: when REQ is nonzero, latch the winner and its REQWR, set GNT and TRUDY on the next edge, and go to ACQ.
REQ-017 ACQ: hold TRUDY and GNT; on BUSACK=1 go to XFER. If the winner's REQ drops first, clear TRUDY and GNT, go to IDLE, and do not pulse DONE.
REQ-018 XFER: assert RD (latched REQWR=0) or WR (REQWR=1) for exactly CYC_LEN cycles; RD and WR are never both 1.
REQ-019 XFER: REQ and REQWR are ignored once XFER is entered; the transfer always completes.
REQ-020 Last XFER cycle: the edge that ends XFER pulses DONE[winner] for one cycle, increments the burst counter, and goes to NEXT.
REQ-021 NEXT (one cycle, TRUDY held, GNT cleared, RD and WR low): if burst count < MAX_BURST and REQ is nonzero, re-arbitrate per REQ-015, latch the new winner, and go to XFER directly when BUSACK=1, otherwise to ACQ.
REQ-022 NEXT: if burst count = MAX_BURST, clear TRUDY and go to HOLD. If REQ=0, clear TRUDY, clear the burst counter, and go to IDLE.
REQ-023 HOLD: TRUDY, GNT, RD and WR are low for GAP cycles, then go to IDLE with the burst counter cleared; requests arriving in HOLD wait.
REQ-024 BUSACK dropping during XFER is a protocol error: the strobe still completes and a sticky internal error flag is set for assertions.
REQ-025 Simultaneous REQ[0] and REQ[1]/REQ[2] in IDLE or NEXT: bit0 wins; the round-robin pointer is unchanged.
REQ-026 GNT is one-hot or zero, and is nonzero only in ACQ and XFER.
REQ-027 Counters saturate: the cycle counter is 4 bits and the burst counter is 4 bits; neither wraps.

Reset
REQ-028 RESET=1 at an edge forces IDLE, TRUDY=RD=WR=0, GNT=DONE=0, burst counter 0, round-robin pointer to blitter, error flag 0.
REQ-029 Reset mid-XFER aborts immediately with no DONE pulse; outputs are valid-low on the first edge with RESET=1.

Structure
REQ-030 The state enum, requester index constants, and parameter defaults live in the shared Slipstream package.
REQ-031 One sub-module, rr_pick2, holds the two-way round-robin choice and its pointer; all else stays in intrude_arbiter.

Verification
REQ-032 REQ=001, REQWR=0, BUSACK high 2 cycles after TRUDY -> GNT=001, RD high exactly 3 cycles, DONE[0] one pulse, TRUDY low after NEXT.
REQ-033 REQ=110 held, BUSACK=1 -> grants alternate 010,100,010,100; after 4 transfers TRUDY low for 2 cycles, then the order resumes at 010.
REQ-034 REQ=111 held -> bit0 wins each arbitration; the round-robin pointer does not move.
REQ-035 REQ=100 dropped in ACQ before BUSACK -> TRUDY and GNT clear next edge, DONE stays 0, state is IDLE.
REQ-036 RESET asserted on the 2nd WR cycle -> WR=TRUDY=GNT=0 next edge, no DONE; a new REQ=001 after release is served normally.

Source files
------------

// File: rtl/intrude_arbiter_pkg.sv
// Shared Slipstream definitions for the intrusion arbiter.
//   state_e       : arbiter FSM states
//   IdxDsp/Blt/Dma: requester bit positions in REQ/REQWR/GNT/DONE
//   *Def          : default timing parameters
//   sat_inc       : 4-bit saturating increment used by all counters
package intrude_arbiter_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAcq,
      StXfer,
      StNext,
      StHold
   } state_e;

   localparam int unsigned IdxDsp = 0;
   localparam int unsigned IdxBlt = 1;
   localparam int unsigned IdxDma = 2;

   localparam int unsigned CycLenDef   = 3;
   localparam int unsigned MaxBurstDef = 4;
   localparam int unsigned GapDef      = 2;

   localparam int unsigned CntW = 4;

   function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
      return (v == {CntW{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser between the blitter and the external DMA.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_req[1:0]     : bit0 blitter request, bit1 DMA request
//   i_adv          : a blitter/DMA transfer just completed
//   i_adv_dma      : with i_adv, 1 = the completed transfer was the DMA's
//   o_pick[1:0]    : one-hot choice (zero when neither requests)
module rr_pick2
   import intrude_arbiter_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_req,
   input  logic       i_adv,
   input  logic       i_adv_dma,
   output logic [1:0] o_pick
);

   // 0: blitter preferred, 1: DMA preferred.
   logic r_ptr;
   logic w_ptr_d;

   // Preference flips to the requester that did not just complete.
   always_comb begin
      w_ptr_d = r_ptr;
      if (i_adv) begin
         w_ptr_d = ~i_adv_dma;
      end
   end

   always_comb begin
      o_pick = 2'b00;
      if (!r_ptr) begin
         if (i_req[0]) begin
            o_pick = 2'b01;
         end else if (i_req[1]) begin
            o_pick = 2'b10;
         end
      end else begin
         if (i_req[1]) begin
            o_pick = 2'b10;
         end else if (i_req[0]) begin
            o_pick = 2'b01;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr <= 1'b0;
      end else begin
         r_ptr <= w_ptr_d;
      end
   end

endmodule

// File: rtl/intrude_arbiter.sv
// Intrusion arbiter: picks one of DSP / blitter / external DMA, requests the
// bus from the intrusion sequencer and runs fixed-length read/write strobes,
// with burst limiting and a forced release gap.
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_req[2:0]      : level requests (bit0 DSP, bit1 blitter, bit2 DMA)
//   i_reqwr[2:0]    : per-requester direction, 1 = write
//   i_busack        : sequencer owns the bus, transfer may run
//   o_trudy         : intrusion request to the sequencer
//   o_rd, o_wr      : transfer strobes
//   o_gnt[2:0]      : one-hot grant, steers the external address/data mux
//   o_done[2:0]     : one-cycle completion pulse to the winner
module intrude_arbiter
   import intrude_arbiter_pkg::*;
#(
   parameter int unsigned CYC_LEN   = CycLenDef,
   parameter int unsigned MAX_BURST = MaxBurstDef,
   parameter int unsigned GAP       = GapDef
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [2:0] i_req,
   input  logic [2:0] i_reqwr,
   input  logic       i_busack,
   output logic       o_trudy,
   output logic       o_rd,
   output logic       o_wr,
   output logic [2:0] o_gnt,
   output logic [2:0] o_done
);

   localparam logic [CntW-1:0] CycLast  = CntW'(CYC_LEN - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'(GAP - 1);
   localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);

   state_e          r_state, w_state_d;
   logic [2:0]      r_win,   w_win_d;
   logic            r_dir,   w_dir_d;
   logic [CntW-1:0] r_cyc,   w_cyc_d;
   logic [CntW-1:0] r_burst, w_burst_d;
   logic [2:0]      r_done,  w_done_d;
   logic            r_err,   w_err_d;

   logic [1:0] w_rr_pick;
   logic [2:0] w_pick;
   logic       w_pick_dir;
   logic       w_rr_adv;
   logic       w_rr_adv_dma;

   rr_pick2 u_rr_pick2 (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_req     ({i_req[IdxDma], i_req[IdxBlt]}),
      .i_adv     (w_rr_adv),
      .i_adv_dma (w_rr_adv_dma),
      .o_pick    (w_rr_pick)
   );

   // DSP overrides the round-robin pair without touching its pointer.
   always_comb begin
      w_pick = '0;
      if (i_req[IdxDsp]) begin
         w_pick[IdxDsp] = 1'b1;
      end else begin
         w_pick[IdxBlt] = w_rr_pick[0];
         w_pick[IdxDma] = w_rr_pick[1];
      end
   end

   assign w_pick_dir   = |(i_reqwr & w_pick);
   assign w_rr_adv_dma = r_win[IdxDma];

   always_comb begin
      w_state_d = r_state;
      w_win_d   = r_win;
      w_dir_d   = r_dir;
      w_cyc_d   = r_cyc;
      w_burst_d = r_burst;
      w_done_d  = '0;
      w_err_d   = r_err;
      w_rr_adv  = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_burst_d = '0;
            if (|i_req) begin
               w_win_d   = w_pick;
               w_dir_d   = w_pick_dir;
               w_state_d = StAcq;
            end
         end
         StAcq: begin
            // A withdrawn request beats a simultaneous BUSACK.
            if (!(|(i_req & r_win))) begin
               w_win_d   = '0;
               w_burst_d = '0;
               w_state_d = StIdle;
            end else if (i_busack) begin
               w_cyc_d   = '0;
               w_state_d = StXfer;
            end
         end
         StXfer: begin
            if (!i_busack) begin
               w_err_d = 1'b1;
            end
            if (r_cyc >= CycLast) begin
               w_done_d  = r_win;
               w_burst_d = sat_inc(r_burst);
               w_rr_adv  = ~r_win[IdxDsp];
               w_state_d = StNext;
            end else begin
               w_cyc_d = sat_inc(r_cyc);
            end
         end
         StNext: begin
            if (r_burst >= BurstMax) begin
               w_cyc_d   = '0;
               w_state_d = StHold;
            end else if (!(|i_req)) begin
               w_burst_d = '0;
               w_state_d = StIdle;
            end else begin
               w_win_d   = w_pick;
               w_dir_d   = w_pick_dir;
               w_cyc_d   = '0;
               w_state_d = i_busack ? StXfer : StAcq;
            end
         end
         StHold: begin
            if (r_cyc >= GapLast) begin
               w_burst_d = '0;
               w_state_d = StIdle;
            end else begin
               w_cyc_d = sat_inc(r_cyc);
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_win   <= '0;
         r_dir   <= 1'b0;
         r_cyc   <= '0;
         r_burst <= '0;
         r_done  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_win   <= w_win_d;
         r_dir   <= w_dir_d;
         r_cyc   <= w_cyc_d;
         r_burst <= w_burst_d;
         r_done  <= w_done_d;
         r_err   <= w_err_d;
      end
   end

   always_comb begin
      o_trudy = 1'b0;
      o_rd    = 1'b0;
      o_wr    = 1'b0;
      o_gnt   = '0;
      case (r_state)
         StAcq: begin
            o_trudy = 1'b1;
            o_gnt   = r_win;
         end
         StXfer: begin
            o_trudy = 1'b1;
            o_gnt   = r_win;
            o_rd    = ~r_dir;
            o_wr    = r_dir;
         end
         StNext: begin
            o_trudy = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign o_done = r_done;

   a_gnt_onehot: assert property (@(posedge i_clk) disable iff (i_reset) $onehot0(o_gnt));
   a_strobe_excl: assert property (@(posedge i_clk) !(o_rd && o_wr));
   // BUSACK lost mid-transfer; sticky until reset.
   c_proto_err: cover property (@(posedge i_clk) r_err);

endmodule

// File: tb/tb_intrude_arbiter.sv
module tb_intrude_arbiter;

   localparam int unsigned CycLen   = 3;
   localparam int unsigned MaxBurst = 4;
   localparam int unsigned Gap      = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] req = '0;
   logic [2:0] reqwr = '0;
   logic       busack = 1'b0;
   logic       trudy, rd, wr;
   logic [2:0] gnt, done;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   intrude_arbiter #(
      .CYC_LEN   (CycLen),
      .MAX_BURST (MaxBurst),
      .GAP       (Gap)
   ) dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_req    (req),
      .i_reqwr  (reqwr),
      .i_busack (busack),
      .o_trudy  (trudy),
      .o_rd     (rd),
      .o_wr     (wr),
      .o_gnt    (gnt),
      .o_done   (done)
   );

   // Reference model: who owns the bus and how much of each phase remains.
   int         m_owner;
   bit         m_bus;
   int         m_xfer_left;
   bit         m_in_next;
   int         m_gap_left;
   int         m_burst;
   int         m_rr;
   bit         m_write;
   logic [2:0] m_done;

   // Observations from the latest sample and running tallies.
   logic       s_trudy, s_rd, s_wr;
   logic [2:0] s_gnt, s_done;
   int         obs_rd;
   logic [2:0] done_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner     = -1;
      m_bus       = 1'b0;
      m_xfer_left = 0;
      m_in_next   = 1'b0;
      m_gap_left  = 0;
      m_burst     = 0;
      m_rr        = 1;
      m_write     = 1'b0;
      m_done      = '0;
   endtask

   task automatic grab();
      if (req[0]) m_owner = 0;
      else if (req[m_rr]) m_owner = m_rr;
      else m_owner = 3 - m_rr;
      m_write = reqwr[m_owner];
   endtask

   // Advance the model by one rising edge using the inputs present at it.
   task automatic model_step();
      if (rst) begin
         model_reset();
         return;
      end
      m_done = '0;
      if (m_gap_left > 0) begin
         m_gap_left--;
         if (m_gap_left == 0) m_burst = 0;
      end else if (m_xfer_left > 0) begin
         m_xfer_left--;
         if (m_xfer_left == 0) begin
            m_done[m_owner] = 1'b1;
            if (m_burst < 15) m_burst++;
            if (m_owner != 0) m_rr = 3 - m_owner;
            m_in_next = 1'b1;
         end
      end else if (m_in_next) begin
         m_in_next = 1'b0;
         if (m_burst >= MaxBurst) begin
            m_bus = 1'b0;
            m_owner = -1;
            m_gap_left = Gap;
         end else if (req == 3'b000) begin
            m_bus = 1'b0;
            m_owner = -1;
            m_burst = 0;
         end else begin
            grab();
            if (busack) m_xfer_left = CycLen;
         end
      end else if (m_bus) begin
         if (!req[m_owner]) begin
            m_bus = 1'b0;
            m_owner = -1;
            m_burst = 0;
         end else if (busack) begin
            m_xfer_left = CycLen;
         end
      end else if (req != 3'b000) begin
         grab();
         m_bus = 1'b1;
      end
   endtask

   task automatic compare_outputs();
      logic [2:0] eg;
      eg = '0;
      if (m_bus && !m_in_next && m_owner >= 0) eg[m_owner] = 1'b1;
      check_eq("trudy", trudy, m_bus);
      check_eq("gnt", gnt, eg);
      check_eq("rd", rd, (m_xfer_left > 0) && !m_write);
      check_eq("wr", wr, (m_xfer_left > 0) && m_write);
      check_eq("done", done, m_done);
      s_trudy = trudy;
      s_rd    = rd;
      s_wr    = wr;
      s_gnt   = gnt;
      s_done  = done;
      if (rd === 1'b1) obs_rd++;
      if (done !== 3'b000) done_q.push_back(done);
   endtask

   task automatic step(input logic [2:0] r, input logic [2:0] w, input logic a, input logic x);
      @(negedge clk);
      compare_outputs();
      req    = r;
      reqwr  = w;
      busack = a;
      rst    = x;
      @(posedge clk);
      model_step();
   endtask

   task automatic clear_obs();
      obs_rd = 0;
      done_q.delete();
   endtask

   initial begin
      logic [2:0] cur_req;
      logic [2:0] first_rr;
      bit         found;
      model_reset();
      clear_obs();
      repeat (2) @(posedge clk);

      // Single DSP read, BUSACK two cycles after TRUDY.
      step(3'b000, 3'b000, 1'b0, 1'b1);
      clear_obs();
      step(3'b001, 3'b000, 1'b0, 1'b0);
      step(3'b001, 3'b000, 1'b0, 1'b0);
      step(3'b001, 3'b000, 1'b0, 1'b0);
      step(3'b001, 3'b000, 1'b1, 1'b0);
      repeat (3) step(3'b000, 3'b000, 1'b1, 1'b0);
      repeat (6) step(3'b000, 3'b000, 1'b0, 1'b0);
      check_eq("dsp_rd_cycles", obs_rd, 3);
      check_eq("dsp_done_count", done_q.size(), 1);
      if (done_q.size() > 0) check_eq("dsp_done_who", done_q[0], 3'b001);
      check_eq("dsp_trudy_end", s_trudy, 1'b0);

      // Blitter and DMA alternate; burst limit then resume at blitter.
      step(3'b000, 3'b000, 1'b0, 1'b1);
      clear_obs();
      repeat (40) step(3'b110, 3'b000, 1'b1, 1'b0);
      check_eq("rr_done_count_ge5", done_q.size() >= 5, 1'b1);
      for (int i = 0; i < 5 && i < done_q.size(); i++) begin
         check_eq($sformatf("rr_order_%0d", i), done_q[i], (i % 2 == 0) ? 3'b010 : 3'b100);
      end

      // DSP wins every time; pointer left at blitter.
      step(3'b000, 3'b000, 1'b0, 1'b1);
      clear_obs();
      repeat (30) step(3'b111, 3'b000, 1'b1, 1'b0);
      check_eq("dsp_prio_any", done_q.size() > 0, 1'b1);
      for (int i = 0; i < done_q.size(); i++) begin
         check_eq($sformatf("dsp_prio_%0d", i), done_q[i], 3'b001);
      end
      clear_obs();
      repeat (20) step(3'b110, 3'b000, 1'b1, 1'b0);
      found = 1'b0;
      first_rr = '0;
      for (int i = 0; i < done_q.size(); i++) begin
         if (!found && done_q[i] != 3'b001) begin
            found = 1'b1;
            first_rr = done_q[i];
         end
      end
      check_eq("ptr_unmoved", first_rr, 3'b010);

      // DMA withdraws during ACQ.
      step(3'b000, 3'b000, 1'b0, 1'b1);
      clear_obs();
      step(3'b100, 3'b000, 1'b0, 1'b0);
      step(3'b100, 3'b000, 1'b0, 1'b0);
      check_eq("acq_gnt", s_gnt, 3'b100);
      step(3'b000, 3'b000, 1'b0, 1'b0);
      step(3'b000, 3'b000, 1'b0, 1'b0);
      check_eq("drop_trudy", s_trudy, 1'b0);
      check_eq("drop_gnt", s_gnt, 3'b000);
      step(3'b000, 3'b000, 1'b0, 1'b0);
      check_eq("drop_no_done", done_q.size(), 0);

      // Reset on the second WR cycle, then a normal DSP read.
      step(3'b000, 3'b000, 1'b0, 1'b1);
      clear_obs();
      step(3'b001, 3'b001, 1'b1, 1'b0);
      step(3'b001, 3'b001, 1'b1, 1'b0);
      step(3'b001, 3'b001, 1'b1, 1'b0);
      step(3'b001, 3'b001, 1'b1, 1'b1);
      check_eq("wr_before_reset", s_wr, 1'b1);
      step(3'b000, 3'b000, 1'b0, 1'b0);
      check_eq("rst_wr", s_wr, 1'b0);
      check_eq("rst_trudy", s_trudy, 1'b0);
      check_eq("rst_gnt", s_gnt, 3'b000);
      check_eq("rst_no_done", done_q.size(), 0);
      clear_obs();
      step(3'b001, 3'b000, 1'b0, 1'b0);
      step(3'b001, 3'b000, 1'b1, 1'b0);
      repeat (3) step(3'b000, 3'b000, 1'b1, 1'b0);
      repeat (4) step(3'b000, 3'b000, 1'b0, 1'b0);
      check_eq("post_rst_rd", obs_rd, 3);
      check_eq("post_rst_done", done_q.size(), 1);

      // Random traffic against the model.
      cur_req = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(7) == 0) cur_req[b] = ~cur_req[b];
         end
         step(cur_req, 3'($urandom), ($urandom_range(3) != 0), ($urandom_range(299) == 0));
      end
      @(negedge clk);
      compare_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
